dma_ram_rd_stream: RTL



---
 rtl/dma_ram_rd_stream_pkg.sv | 19 +
 rtl/dma_ram_rd_stream_skid.sv | 48 ++++
 rtl/dma_ram_rd_stream.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ram_rd_stream_pkg.sv
// Shared types for the DMA RAM row reader feeding an AXI-stream port.
// FSM state encoding and descriptor completion codes.
package dma_ram_rd_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR  = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ZERO_LEN = 2'd1,
    ERR_ALIGN    = 2'd2,
    ERR_RANGE    = 2'd3
  } err_e;

endpackage

// File: rtl/dma_ram_rd_stream_skid.sv
// Two-entry output buffer with registered valid, full throughput.
// Used only when DMA_RAM_RD_STREAM_OUT_REG_EN is defined.
module dma_ram_rd_stream_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  logic [DW-1:0] mem_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    cnt_q;
  logic          push;
  logic          pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/dma_ram_rd_stream.sv
// Segmented DMA RAM range reader emitting one RAM row per AXI-stream beat.
// Define DMA_RAM_RD_STREAM_OUT_REG_EN to register m_axis_* via a skid buffer.
module dma_ram_rd_stream
  import dma_ram_rd_stream_pkg::*;
#(
  parameter int SEG_COUNT       = 2,
  parameter int SEG_DATA_WIDTH  = 128,
  parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH/8,
  parameter int SEG_ADDR_WIDTH  = 7,
  parameter int LEN_WIDTH       = 16,
  parameter int TAG_WIDTH       = 8,
  localparam int W              = SEG_COUNT*SEG_BE_WIDTH,
  localparam int RAM_ADDR_WIDTH = SEG_ADDR_WIDTH + $clog2(W)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [RAM_ADDR_WIDTH-1:0]           s_desc_addr,
  input  logic [LEN_WIDTH-1:0]                s_desc_len,
  input  logic [TAG_WIDTH-1:0]                s_desc_tag,
  input  logic                                s_desc_valid,
  output logic                                s_desc_ready,
  output logic [TAG_WIDTH-1:0]                m_status_tag,
  output logic [1:0]                          m_status_error,
  output logic                                m_status_valid,
  output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr,
  output logic [SEG_COUNT-1:0]                ram_rd_cmd_valid,
  input  logic [SEG_COUNT-1:0]                ram_rd_cmd_ready,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_rd_resp_data,
  input  logic [SEG_COUNT-1:0]                ram_rd_resp_valid,
  output logic [SEG_COUNT-1:0]                ram_rd_resp_ready,
  output logic [W*8-1:0]                      m_axis_tdata,
  output logic [W-1:0]                        m_axis_tkeep,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [TAG_WIDTH-1:0]                m_axis_tid
);

  localparam int OW = $clog2(W);
  localparam int CW = LEN_WIDTH + 1 - OW;
  localparam int EW = ((RAM_ADDR_WIDTH > LEN_WIDTH) ?
                       RAM_ADDR_WIDTH : LEN_WIDTH) + 1;

  state_e                    state_q;
  logic                      ready_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [W-1:0]              keep_last_q;
  logic [CW-1:0]             last_q;
  logic [CW-1:0]             beat_q;
  logic [CW-1:0]             iss_q;
  logic [SEG_ADDR_WIDTH-1:0] row_q;
  logic [SEG_COUNT-1:0]      cmd_vld_q;
  logic [SEG_COUNT-1:0]      acc_q;
  logic                      st_vld_q;
  logic [TAG_WIDTH-1:0]      st_tag_q;
  err_e                      st_err_q;

  err_e                      chk_err;
  logic [EW-1:0]             end_addr;
  logic [LEN_WIDTH:0]        len_rnd;
  logic [CW-1:0]             n_beats;
  logic [OW-1:0]             len_rem;
  logic [W-1:0]              keep_last;

  logic [SEG_COUNT-1:0]      cmd_hs;
  logic [SEG_COUNT-1:0]      acc_nxt;
  logic                      row_done;

  logic                      all_valid;
  logic                      beat_avail;
  logic                      beat_last;
  logic [W-1:0]              beat_keep;
  logic                      in_ready;
  logic                      in_hs;
  logic                      out_last_hs;

  // Range check is widened so long lengths cannot wrap past the limit.
  always_comb begin
    end_addr = EW'(s_desc_addr) + EW'(s_desc_len);
    if (s_desc_len == '0) begin
      chk_err = ERR_ZERO_LEN;
    end else if (s_desc_addr[OW-1:0] != '0) begin
      chk_err = ERR_ALIGN;
    end else if (end_addr > (EW'(1) << RAM_ADDR_WIDTH)) begin
      chk_err = ERR_RANGE;
    end else begin
      chk_err = ERR_NONE;
    end
  end

  assign len_rnd   = {1'b0, s_desc_len} + (LEN_WIDTH+1)'(W-1);
  assign n_beats   = len_rnd[LEN_WIDTH:OW];
  assign len_rem   = s_desc_len[OW-1:0];
  assign keep_last = (len_rem == '0) ? '1 :
                     ((W'(1) << len_rem) - W'(1));

  assign cmd_hs   = cmd_vld_q & ram_rd_cmd_ready;
  assign acc_nxt  = acc_q | cmd_hs;
  assign row_done = &acc_nxt;

  assign ram_rd_cmd_addr  = {SEG_COUNT{row_q}};
  assign ram_rd_cmd_valid = cmd_vld_q;

  assign all_valid  = &ram_rd_resp_valid;
  assign beat_avail = (state_q == S_READ) && all_valid;
  assign beat_last  = (beat_q == last_q);
  assign beat_keep  = beat_last ? keep_last_q : '1;
  assign in_hs      = beat_avail && in_ready;

`ifdef DMA_RAM_RD_STREAM_OUT_REG_EN
  localparam int DW = W*8 + W + 1 + TAG_WIDTH;

  logic [DW-1:0] sk_out;

  dma_ram_rd_stream_skid #(
    .DW (DW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   ({ram_rd_resp_data, beat_keep, beat_last, tag_q}),
    .in_valid_i  (beat_avail),
    .in_ready_o  (in_ready),
    .out_data_o  (sk_out),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid} = sk_out;
`else
  assign in_ready      = m_axis_tready;
  assign m_axis_tvalid = beat_avail;
  assign m_axis_tdata  = beat_avail ? ram_rd_resp_data : '0;
  assign m_axis_tkeep  = beat_avail ? beat_keep : '0;
  assign m_axis_tlast  = beat_avail && beat_last;
  assign m_axis_tid    = beat_avail ? tag_q : '0;
`endif

  assign out_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Idle and error states swallow whatever the RAM still has in flight.
  always_comb begin
    ram_rd_resp_ready = '0;
    unique case (state_q)
      S_IDLE, S_ERR: ram_rd_resp_ready = '1;
      S_READ:        ram_rd_resp_ready = {SEG_COUNT{in_hs}};
      default:       ram_rd_resp_ready = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      tag_q       <= '0;
      keep_last_q <= '0;
      last_q      <= '0;
      beat_q      <= '0;
      iss_q       <= '0;
      row_q       <= '0;
      cmd_vld_q   <= '0;
      acc_q       <= '0;
      st_vld_q    <= 1'b0;
      st_tag_q    <= '0;
      st_err_q    <= ERR_NONE;
    end else begin
      st_vld_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && s_desc_valid) begin
            ready_q <= 1'b0;
            tag_q   <= s_desc_tag;
            if (chk_err != ERR_NONE) begin
              state_q  <= S_ERR;
              st_vld_q <= 1'b1;
              st_tag_q <= s_desc_tag;
              st_err_q <= chk_err;
            end else begin
              state_q     <= S_READ;
              row_q       <= s_desc_addr[RAM_ADDR_WIDTH-1:OW];
              iss_q       <= n_beats;
              last_q      <= n_beats - 1'b1;
              beat_q      <= '0;
              keep_last_q <= keep_last;
              cmd_vld_q   <= '1;
              acc_q       <= '0;
            end
          end
        end
        S_ERR: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        S_READ: begin
          if (|cmd_vld_q) begin
            if (row_done) begin
              acc_q     <= '0;
              row_q     <= row_q + 1'b1;
              iss_q     <= iss_q - 1'b1;
              cmd_vld_q <= (iss_q > CW'(1)) ? '1 : '0;
            end else begin
              acc_q     <= acc_nxt;
              cmd_vld_q <= cmd_vld_q & ~cmd_hs;
            end
          end
          if (in_hs) begin
            beat_q <= beat_q + 1'b1;
          end
          if (out_last_hs) begin
            state_q  <= S_DONE;
            st_vld_q <= 1'b1;
            st_tag_q <= tag_q;
            st_err_q <= ERR_NONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_desc_ready   = ready_q;
  assign m_status_valid = st_vld_q;
  assign m_status_tag   = st_tag_q;
  assign m_status_error = st_err_q;

endmodule
